// File: rtl/gates_selftest_ctrl.sv
// Built-in self-test sequencer for the basic gate block: sweeps {A,B}, samples gate outputs, scores them.
// Optional fault-injection port enabled by defining GATES_SELFTEST_INJECT_EN.
module gates_selftest_ctrl #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned LOOPS      = 1,
   parameter int unsigned ERR_W      = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   output logic             oA,
   output logic             oB,
   input  logic             iAND,
   input  logic             iOR,
   input  logic             iNOT,
   input  logic             iNAND,
   input  logic             iNAND2,
`ifdef GATES_SELFTEST_INJECT_EN
   input  logic             iInject,
`endif
   output logic             oBusy,
   output logic             oDone,
   output logic             oPass,
   output logic [ERR_W-1:0] oErrCnt,
   output logic [4:0]       oFailMask
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [3:0] LOOP_LAST   = 4'(LOOPS - 1);

   state_t           state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [3:0]       loop_q, loop_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [4:0]       mask_q, mask_d;
   logic             and_s;
   logic [4:0]       mism;

   function automatic logic [2:0] popcnt5(input logic [4:0] m);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < 5; i++) c = c + 3'(m[i]);
      return c;
   endfunction

   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                input logic [2:0]       inc);
      logic [ERR_W+2:0] sum;
      logic [ERR_W+2:0] top;
      sum = {3'b000, acc} + {{ERR_W{1'b0}}, inc};
      top = {3'b000, {ERR_W{1'b1}}};
      return (sum > top) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
   endfunction

`ifdef GATES_SELFTEST_INJECT_EN
   assign and_s = iAND ^ iInject;
`else
   assign and_s = iAND;
`endif

   // Bit order matches oFailMask: {NAND2,NAND,NOT,OR,AND}
   assign mism = {iNAND2 ^ ~(a_q & b_q),
                  iNAND  ^ ~(a_q & b_q),
                  iNOT   ^ ~a_q,
                  iOR    ^ (a_q | b_q),
                  and_s  ^ (a_q & b_q)};

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= S_IDLE;
         vec_q   <= 2'd0;
         loop_q  <= 4'd0;
         cnt_q   <= 4'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         mask_q  <= 5'd0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         loop_q  <= loop_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      loop_d  = loop_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      pass_d  = pass_q;
      err_d   = err_q;
      mask_d  = mask_q;
      case (state_q)
         S_IDLE: begin
            if (iStart) begin
               state_d = S_DRIVE;
               vec_d   = 2'd0;
               loop_d  = 4'd0;
               err_d   = '0;
               mask_d  = 5'd0;
               pass_d  = 1'b0;
            end
         end
         S_DRIVE: begin
            a_d     = vec_q[1];
            b_d     = vec_q[0];
            cnt_d   = 4'd0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
            else                      cnt_d   = cnt_q + 4'd1;
         end
         S_CHECK: begin
            mask_d = mask_q | mism;
            err_d  = sat_add(err_q, popcnt5(mism));
            vec_d  = vec_q + 2'd1;
            state_d = S_DRIVE;
            if (vec_q == 2'd3) begin
               loop_d = loop_q + 4'd1;
               if (loop_q == LOOP_LAST) begin
                  state_d = S_DONE;
                  a_d     = 1'b0;
                  b_d     = 1'b0;
               end
            end
         end
         S_DONE: begin
            pass_d  = (err_q == '0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign oA        = a_q;
   assign oB        = b_q;
   assign oBusy     = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
   assign oDone     = (state_q == S_DONE);
   assign oPass     = pass_q;
   assign oErrCnt   = err_q;
   assign oFailMask = mask_q;

endmodule

// File: tb/tb_gates_selftest_ctrl.sv
// Bench for gates_selftest_ctrl: a behavioural gate block with per-vector fault flips and a
// stuck-at-0 OR option, scored against expectations computed from the gate truth rules.
module tb_gates_selftest_ctrl;

   localparam int SC   = 2;
   localparam int LP   = 1;
   localparam int PER  = SC + 2;
   localparam int LAT  = 1 + 4 * LP * PER;
   localparam int EMAX = 15;

   logic       iClk = 1'b0;
   logic       iRst, iStart;
   logic       oA, oB, oBusy, oDone, oPass;
   logic       iAND, iOR, iNOT, iNAND, iNAND2;
   logic [3:0] oErrCnt;
   logic [4:0] oFailMask;
   logic       inject;
   logic       stuck_or;
   logic [4:0] flip [4];

   int vectors     = 0;
   int miscompares = 0;

   gates_selftest_ctrl #(.SETTLE_CYC(SC), .LOOPS(LP), .ERR_W(4)) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iStart   (iStart),
      .oA       (oA),
      .oB       (oB),
      .iAND     (iAND),
      .iOR      (iOR),
      .iNOT     (iNOT),
      .iNAND    (iNAND),
      .iNAND2   (iNAND2),
`ifdef GATES_SELFTEST_INJECT_EN
      .iInject  (inject),
`endif
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oPass    (oPass),
      .oErrCnt  (oErrCnt),
      .oFailMask(oFailMask)
   );

   always #5 iClk = ~iClk;

   // Gate block under test, with optional faults
   assign iAND   = (oA & oB) ^ flip[{oA, oB}][0];
   assign iOR    = stuck_or ? 1'b0 : ((oA | oB) ^ flip[{oA, oB}][1]);
   assign iNOT   = ~oA ^ flip[{oA, oB}][2];
   assign iNAND  = ~(oA & oB) ^ flip[{oA, oB}][3];
   assign iNAND2 = ~(oA & oB) ^ flip[{oA, oB}][4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"},    oA, 0);
      check({tag, "_b"},    oB, 0);
      check({tag, "_busy"}, oBusy, 0);
      check({tag, "_done"}, oDone, 0);
      check({tag, "_pass"}, oPass, 0);
      check({tag, "_err"},  oErrCnt, 0);
      check({tag, "_mask"}, oFailMask, 0);
   endtask

   // Expected score of one run, derived from the truth table of each gate
   task automatic expect_run(output int exp_err, output logic [4:0] exp_mask);
      int total;
      logic a, b;
      logic [4:0] m;
      total    = 0;
      exp_mask = 5'd0;
      for (int v = 0; v < 4; v++) begin
         a = (v >= 2);
         b = (v % 2 == 1);
         m = flip[v];
         if (stuck_or) m[1] = a | b;
         if (inject)   m[0] = ~m[0];
         exp_mask = exp_mask | m;
         total    = total + $countones(m);
      end
      total   = total * LP;
      exp_err = (total > EMAX) ? EMAX : total;
   endtask

   task automatic run(input int restart_at, input int rst_at);
      int n, dones, exp_err;
      logic [4:0] exp_mask;
      expect_run(exp_err, exp_mask);
      @(negedge iClk);
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      n = 1;
      while (n < LAT + 40) begin
         iStart = (n == restart_at);
         if (n == rst_at) begin
            iRst = 1'b1;
            #1;
            check_all_zero("midrst");
            @(negedge iClk);
            iRst = 1'b0;
            dones = 0;
            for (int k = 0; k < LAT + 10; k++) begin
               @(negedge iClk);
               if (oDone) dones++;
            end
            check("no_done_after_rst", dones, 0);
            return;
         end
         check("busy", oBusy, (n < LAT));
         if (n < LAT && ((n - 1) % PER) != 0)
            check("ab_sweep", {oA, oB}, ((n - 1) / PER) % 4);
         if (oDone) break;
         @(negedge iClk);
         n++;
      end
      iStart = 1'b0;
      check("done_lat", n, LAT);
      @(negedge iClk);
      check("done_pulse", oDone, 0);
      check("idle_ab",    {oA, oB}, 0);
      check("pass",       oPass, (exp_err == 0));
      check("errcnt",     oErrCnt, exp_err);
      check("failmask",   oFailMask, exp_mask);
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge iClk);
         if (oDone) dones++;
      end
      check("extra_done", dones, 0);
      check("errcnt_held", oErrCnt, exp_err);
      check("pass_held",   oPass, (exp_err == 0));
   endtask

   task automatic clear_faults();
      for (int v = 0; v < 4; v++) flip[v] = 5'd0;
      stuck_or = 1'b0;
      inject   = 1'b0;
   endtask

   initial begin
      iRst   = 1'b1;
      iStart = 1'b0;
      clear_faults();
      #1;
      check_all_zero("rst");
      repeat (2) @(negedge iClk);
      iRst = 1'b0;
      @(negedge iClk);
      check_all_zero("post_rst");

      run(0, 0);

      stuck_or = 1'b1;
      run(0, 0);
      clear_faults();

      run(5, 0);

      flip[1] = 5'b10101;
      run(0, 8);
      clear_faults();
      run(0, 0);

      for (int v = 0; v < 4; v++) flip[v] = 5'h1f;
      run(0, 0);
      clear_faults();

      for (int r = 0; r < 10; r++) begin
         for (int v = 0; v < 4; v++) flip[v] = 5'($urandom) & 5'($urandom);
         stuck_or = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 3)) @(negedge iClk);
         run(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, LAT - 1)) : 0, 0);
      end
      clear_faults();

`ifdef GATES_SELFTEST_INJECT_EN
      inject = 1'b1;
      run(0, 0);
      clear_faults();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
